// File: rtl/block_control.sv
`default_nettype none
// =============================================================================
//  Module   : block_control
//  Brief    : Active-piece controller for a 20x20 falling-block playfield.
//             Handles spawn, gravity, user moves and rotation, lock and game over.
//  Revision : 1.0  initial release
// =============================================================================
module block_control #(
    parameter int GRAVITY_TICKS = 50000000,
    parameter int SPAWN_X       = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         spawn,
    input  logic [15:0]  spawn_matrix,
    input  logic         move_left,
    input  logic         move_right,
    input  logic         rotate_cw,
    input  logic         soft_drop,
    input  logic [399:0] field,
    output logic [4:0]   block_pos_x,
    output logic [4:0]   block_pos_y,
    output logic [15:0]  block_matrix,
    output logic [9:0]   rotate,
    output logic         en,
    output logic         lock,
    output logic         game_over
);

    localparam int               CNT_W     = $clog2(GRAVITY_TICKS);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(GRAVITY_TICKS - 1);
    localparam logic [5:0]       SPAWN_COL = 6'(SPAWN_X);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_LOCK   = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t           state_q;
    logic [4:0]       x_q;
    logic [4:0]       y_q;
    logic [15:0]      mat_q;
    logic [9:0]       rot_q;
    logic             en_q;
    logic             lock_q;
    logic             over_q;
    logic [CNT_W-1:0] grav_q;

    logic [5:0]       cand_x;
    logic [5:0]       cand_y;
    logic [15:0]      cand_m;
    logic             grav_tick;
    logic             act_down;
    logic             act_rot;
    logic             act_any;
    logic             edge_block;
    logic             cand_hit;
    logic             spawn_hit;

    // Sums stay at 6 bits so a piece hanging past column/row 19 is seen as a hit.
    function automatic logic collides(input logic [5:0]   x,
                                      input logic [5:0]   y,
                                      input logic [15:0]  m,
                                      input logic [399:0] f);
        logic       hit;
        logic [5:0] cx;
        logic [5:0] cy;
        logic [8:0] idx;
        hit = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cx  = x + 6'(c);
                cy  = y + 6'(r);
                idx = 9'(cy) * 9'd20 + 9'(cx);
                if (m[4'(r * 4 + c)]) begin
                    if (cx >= 6'd20 || cy >= 6'd20) begin
                        hit = 1'b1;
                    end else if (f[idx]) begin
                        hit = 1'b1;
                    end
                end
            end
        end
        return hit;
    endfunction

    function automatic logic [15:0] rot_cw(input logic [15:0] m);
        logic [15:0] n;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                n[4'(r * 4 + c)] = m[4'((3 - c) * 4 + r)];
            end
        end
        return n;
    endfunction

    // One candidate per cycle, chosen by action priority.
    always_comb begin
        grav_tick  = (grav_q == TICK_LAST);
        act_down   = grav_tick || soft_drop;
        act_rot    = 1'b0;
        act_any    = 1'b1;
        edge_block = 1'b0;
        cand_x     = {1'b0, x_q};
        cand_y     = {1'b0, y_q};
        cand_m     = mat_q;
        if (act_down) begin
            cand_y = cand_y + 6'd1;
        end else if (rotate_cw) begin
            cand_m  = rot_cw(mat_q);
            act_rot = 1'b1;
        end else if (move_left) begin
            if (x_q == 5'd0) begin
                edge_block = 1'b1;
            end else begin
                cand_x = cand_x - 6'd1;
            end
        end else if (move_right) begin
            cand_x = cand_x + 6'd1;
        end else begin
            act_any = 1'b0;
        end
        cand_hit  = edge_block || cand_x[5] || cand_y[5] ||
                    collides(cand_x, cand_y, cand_m, field);
        spawn_hit = collides(SPAWN_COL, 6'd0, spawn_matrix, field);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mat_q   <= '0;
            rot_q   <= '0;
            en_q    <= 1'b0;
            lock_q  <= 1'b0;
            over_q  <= 1'b0;
            grav_q  <= '0;
        end else begin
            en_q   <= 1'b0;
            lock_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    grav_q <= '0;
                    if (spawn) begin
                        x_q   <= SPAWN_COL[4:0];
                        y_q   <= '0;
                        mat_q <= spawn_matrix;
                        rot_q <= '0;
                        if (spawn_hit) begin
                            state_q <= S_OVER;
                            over_q  <= 1'b1;
                        end else begin
                            state_q <= S_ACTIVE;
                            en_q    <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    grav_q <= act_down ? '0 : grav_q + CNT_W'(1);
                    if (act_any) begin
                        if (!cand_hit) begin
                            x_q   <= cand_x[4:0];
                            y_q   <= cand_y[4:0];
                            mat_q <= cand_m;
                            en_q  <= 1'b1;
                            if (act_rot) begin
                                rot_q <= rot_q + 10'd1;
                            end
                        end else if (act_down) begin
                            state_q <= S_LOCK;
                            lock_q  <= 1'b1;
                        end
                    end
                end
                S_LOCK: begin
                    state_q <= S_IDLE;
                    grav_q  <= '0;
                end
                S_OVER: begin
                    over_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign block_pos_x  = x_q;
    assign block_pos_y  = y_q;
    assign block_matrix = mat_q;
    assign rotate       = rot_q;
    assign en           = en_q;
    assign lock         = lock_q;
    assign game_over    = over_q;

endmodule
`default_nettype wire
